ps2_host_port: RTL and testbench
================================

// Module: ps2_host_port
// PURPOSE
//  Parametrised bidirectional PS/2 host port; successor to the receive-only mouse block. Receives
//  device frames into an RX FIFO and sends host-to-device command bytes (e.g. 0xF4, 0xFF) with ack.
//  Checks parity, framing and timeouts. Sits on the I/O bus behind io_cs/addr. Pads are
//  open-drain; the top level resolves t_clk/t_data (0 = drive low, 1 = release).
// PARAMETERS
//  FIFO_AW        3       log2 RX FIFO depth (depth 8)
//  FILTER_LEN     4       consecutive equal samples needed to accept a new pin level
//  INHIBIT_CYCLES 5000    clk cycles t_clk is held low before TX (100 us at 50 MHz)
//  TIMEOUT_CYCLES 100000  max clk cycles between device clock falls inside a frame (2 ms)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-low reset
//  io_cs        in   1  bus select; the access occurs on the clk edge where io_cs=1
//  io_we        in   1  1 = write, 0 = read
//  addr         in   2  0 RX data, 1 status, 2 TX data, 3 control
//  wdata        in   8  write data
//  data         out  8  read data (combinational from addr)
//  rda          out  1  RX FIFO non-empty
//  irq          out  1  rda | any error flag
//  t_clk        out  1  0 = pull PS/2 clock low, 1 = release
//  t_data       out  1  0 = pull PS/2 data low, 1 = release
//  MOUSE_CLOCK  in   1  PS/2 clock pin level (asynchronous)
//  MOUSE_DATA   in   1  PS/2 data pin level (asynchronous)
// BEHAVIOUR
//  Reset (rst=0, any time, including mid-frame):
//  - t_clk=t_data=1, FIFO empty, rda=0, irq=0.
//  - All flags 0, rx_en=1, FSMs idle.
//  Input conditioning:
//  - 2-flop synchroniser plus FILTER_LEN glitch filter.
//  - A fall is detected 2+FILTER_LEN cycles after the pin edge.
//  - Sampling uses the filtered MOUSE_DATA at the filtered clock fall.
//  Frame format: start 0, 8 data bits LSB first, odd parity, stop 1.
//  RX FSM (RX_IDLE -> RX_BITS -> RX_PAR -> RX_STOP):
//  - Active only when rx_en=1 and TX is idle.
//  - Start bit sampled 1: treat as a glitch, stay in RX_IDLE, no flag.
//  - Parity bad: set parity_err and drop the byte. Stop bit 0: set frame_err and drop the byte.
//  - Good byte: push to the FIFO the cycle after the stop fall; rda=1 the next cycle.
//  - FIFO full on a good byte: drop the byte and set overflow; FIFO contents unchanged.
//  - More than TIMEOUT_CYCLES with no fall mid-frame: set timeout, discard partial byte, return to RX_IDLE.
//  TX FSM (TX_IDLE -> TX_INHIBIT -> TX_REQ -> TX_BITS -> TX_STOP -> TX_ACK -> TX_IDLE):
//  - Write to addr 2 while idle latches the byte and aborts any RX frame in progress (no flag).
//  - TX_INHIBIT: t_clk=0 for INHIBIT_CYCLES.
//  - TX_REQ: t_data=0, then t_clk=1 the next cycle.
//  - TX_BITS: after each device clock fall, drive the next bit on t_data (0 -> t_data=0, 1 -> t_data=1).
//    Order: d0..d7, then odd parity.
//  - TX_STOP: on the fall after the parity bit, release t_data.
//  - TX_ACK: at the next fall, sample MOUSE_DATA. 0 = ack; 1 sets ack_err. Return to TX_IDLE.
//  - Timeout applies in every TX state after TX_INHIBIT: set timeout, release both lines, go idle.
//  - Write to addr 2 while tx_busy: ignored.
//  Register map:
//  - addr 0 read: FIFO head; 0x00 when empty. Pop on the edge; popping when empty has no effect.
//  - addr 1 read: {rx_en, tx_busy, rda, ack_err, timeout, overflow, frame_err, parity_err}.
//  - addr 3 write: bit0 clears all flags; bit1 flushes the FIFO; bit2 sets rx_en.
//  Simultaneous events:
//  - Push and pop on the same cycle, including when full: both succeed, count unchanged, no overflow.
//  - Flush and push on the same cycle: flush wins, byte lost, no flag.
//  - Flag clear and a new error on the same cycle: the error wins (flag stays 1).
//  - Pointers wrap modulo 2^FIFO_AW; the count field is FIFO_AW+1 bits.
// TESTING
//  1. Device sends 0xFA (parity 1, stop 1) -> rda=1; addr 0 read =0xFA; next addr 1 read bit5=0.
//  2. Device sends 0xFA with parity 0 -> parity_err=1, rda=0, irq=1; addr 3 wdata=0x01 -> flags 0, irq=0.
//  3. Nine good bytes 0x01..0x09 with no reads -> overflow=1; eight reads return 0x01..0x08; rda=0.
//  4. Write 0xF4 to addr 2 (INHIBIT_CYCLES=50) -> t_clk low 50 cycles, then t_data=0.
//     Bits 0,0,1,0,1,1,1,1 + parity 0; device ack 0 -> ack_err=0, tx_busy=0.
//  5. Device stops clocking after 4 bits (TIMEOUT_CYCLES=200) -> timeout=1 after 200 cycles;
//     the next full 0xAA frame is received correctly.
//  6. Assert rst mid-TX at bit 3 -> t_clk=t_data=1 immediately; status reads 0x80.

Source files
------------

// File: rtl/ps2_host_port.sv
// Bidirectional PS/2 host port: filtered pin sampling, RX FIFO, host-to-device
// command transmission with ack check, and parity/framing/timeout error flags.
module ps2_host_port #(
  parameter int FIFO_AW        = 3,
  parameter int FILTER_LEN     = 4,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_cs,
  input  logic       io_we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] data,
  output logic       rda,
  output logic       irq,
  output logic       t_clk,
  output logic       t_data,
  input  logic       MOUSE_CLOCK,
  input  logic       MOUSE_DATA
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FCW   = $clog2(FILTER_LEN + 1);
  localparam int ICW   = $clog2(INHIBIT_CYCLES + 1);
  localparam int TCW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_PAR, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_INHIBIT, TX_REQ, TX_BITS, TX_STOP, TX_ACK} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  // Index 1 is the PS/2 clock, index 0 is the PS/2 data line.
  logic [1:0]     sync1, sync2, filt, filt_d;
  logic [FCW-1:0] flt_cnt [2];
  logic           fall, dat_f;

  logic [2:0]         rx_cnt;
  logic [7:0]         rx_sr;
  logic               rx_par, rx_shift, rx_cap_par, rx_good, push_q;
  logic [7:0]         tx_byte;
  logic [3:0]         tx_cnt;
  logic               tx_bit;
  logic [ICW-1:0]     inh_cnt;
  logic [TCW-1:0]     to_cnt;
  logic               frame_active, to_hit, rx_active;
  logic               set_perr, set_ferr, set_ack;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, pop, do_wr, flush, clr, wr_tx, rx_en;
  logic [4:0]         flags;   // {ack_err, timeout, overflow, frame_err, parity_err}
  logic [4:0]         set_vec;

  assign wr_tx = io_cs & io_we & (addr == 2'd2);
  assign flush = io_cs & io_we & (addr == 2'd3) & wdata[1];
  assign clr   = io_cs & io_we & (addr == 2'd3) & wdata[0];
  assign pop   = io_cs & ~io_we & (addr == 2'd0) & (count != '0);
  assign full  = (count == (FIFO_AW+1)'(DEPTH));
  assign do_wr = push_q & (~full | pop) & ~flush;

  assign fall  = filt_d[1] & ~filt[1];
  assign dat_f = filt[0];

  // Synchronise both pins and only accept a level held for FILTER_LEN samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      filt_d     <= 2'b11;
      flt_cnt[0] <= '0;
      flt_cnt[1] <= '0;
    end else begin
      sync1  <= {MOUSE_CLOCK, MOUSE_DATA};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FCW'(FILTER_LEN - 1)) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A frame is in flight whenever either direction is waiting on device clocks.
  assign frame_active = (rx_state != RX_IDLE) ||
                        (tx_state == TX_BITS) || (tx_state == TX_STOP) || (tx_state == TX_ACK);
  assign to_hit    = frame_active && (to_cnt == TCW'(TIMEOUT_CYCLES));
  assign rx_active = rx_en && (tx_state == TX_IDLE) && !wr_tx;

  // Watchdog on the gap between device clock falls, plus the inhibit timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt  <= '0;
      inh_cnt <= '0;
    end else begin
      to_cnt  <= (!frame_active || fall || to_hit) ? '0 : to_cnt + 1'b1;
      inh_cnt <= (tx_state == TX_INHIBIT) ? inh_cnt + 1'b1 : '0;
    end
  end

  // State registers for both directions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  // RX next state: a start bit of 1 is a glitch; errors are judged at the stop fall.
  always_comb begin
    rx_next    = rx_state;
    rx_shift   = 1'b0;
    rx_cap_par = 1'b0;
    rx_good    = 1'b0;
    set_perr   = 1'b0;
    set_ferr   = 1'b0;
    if (!rx_active) begin
      rx_next = RX_IDLE;
    end else if (to_hit && rx_state != RX_IDLE) begin
      rx_next = RX_IDLE;
    end else if (fall) begin
      case (rx_state)
        RX_IDLE: if (!dat_f) rx_next = RX_BITS;
        RX_BITS: begin
          rx_shift = 1'b1;
          if (rx_cnt == 3'd7) rx_next = RX_PAR;
        end
        RX_PAR: begin
          rx_cap_par = 1'b1;
          rx_next    = RX_STOP;
        end
        default: begin
          rx_next = RX_IDLE;
          if (!(^{rx_sr, rx_par})) set_perr = 1'b1;
          else if (!dat_f)         set_ferr = 1'b1;
          else                     rx_good  = 1'b1;
        end
      endcase
    end
  end

  // RX shift register, bit counter and the delayed FIFO push request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt <= '0;
      push_q <= 1'b0;
    end else begin
      push_q <= rx_good;
      if (rx_state == RX_IDLE) rx_cnt <= '0;
      else if (rx_shift)       rx_cnt <= rx_cnt + 1'b1;
    end
  end

  // RX data capture, LSB arrives first.
  always_ff @(posedge clk) begin
    if (rx_shift)   rx_sr  <= {dat_f, rx_sr[7:1]};
    if (rx_cap_par) rx_par <= dat_f;
  end

  // TX next state: inhibit, request-to-send, clock out bits, release, check ack.
  always_comb begin
    tx_next = tx_state;
    set_ack = 1'b0;
    case (tx_state)
      TX_IDLE:    if (wr_tx) tx_next = TX_INHIBIT;
      TX_INHIBIT: if (inh_cnt == ICW'(INHIBIT_CYCLES - 1)) tx_next = TX_REQ;
      TX_REQ:     tx_next = TX_BITS;
      TX_BITS: begin
        if (to_hit)                    tx_next = TX_IDLE;
        else if (fall && tx_cnt == 4'd8) tx_next = TX_STOP;
      end
      TX_STOP: begin
        if (to_hit)    tx_next = TX_IDLE;
        else if (fall) tx_next = TX_ACK;
      end
      TX_ACK: begin
        if (to_hit) begin
          tx_next = TX_IDLE;
        end else if (fall) begin
          tx_next = TX_IDLE;
          set_ack = dat_f;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // TX bit sequencer: start bit in TX_REQ, then d0..d7 and odd parity per fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt <= '0;
      tx_bit <= 1'b1;
    end else if (tx_state == TX_REQ) begin
      tx_cnt <= '0;
      tx_bit <= 1'b0;
    end else if (tx_state == TX_BITS && fall && !to_hit) begin
      tx_cnt <= tx_cnt + 1'b1;
      tx_bit <= (tx_cnt < 4'd8) ? tx_byte[tx_cnt[2:0]] : ~^tx_byte;
    end
  end

  // Command byte latch.
  always_ff @(posedge clk) begin
    if (wr_tx && tx_state == TX_IDLE) tx_byte <= wdata;
  end

  assign t_clk  = !((tx_state == TX_INHIBIT) || (tx_state == TX_REQ));
  assign t_data = (tx_state == TX_REQ) ? 1'b0 :
                  ((tx_state == TX_BITS) || (tx_state == TX_STOP)) ? tx_bit : 1'b1;

  // FIFO pointers and occupancy; flush beats any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= rx_sr;
  end

  assign set_vec = {set_ack, to_hit, push_q & full & ~pop & ~flush, set_ferr, set_perr};

  // Sticky flags; a new error on the clear cycle keeps its flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags <= '0;
      rx_en <= 1'b1;
    end else begin
      flags <= (flags & ~{5{clr}}) | set_vec;
      if (io_cs && io_we && addr == 2'd3 && wdata[2]) rx_en <= 1'b1;
    end
  end

  assign rda = (count != '0);
  assign irq = rda | (|flags);

  // Combinational read mux.
  always_comb begin
    data = 8'h00;
    case (addr)
      2'd0:    data = rda ? mem[rd_ptr] : 8'h00;
      2'd1:    data = {rx_en, (tx_state != TX_IDLE), rda, flags};
      default: data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_port.sv
// Bench for ps2_host_port: a wired-AND PS/2 device model drives frames and
// clocks host commands; a queue-based model predicts FIFO and flag state.
module tb_ps2_host_port;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       io_cs = 1'b0, io_we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] data;
  logic       rda, irq, t_clk, t_data;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  wire        MOUSE_CLOCK = dev_clk & t_clk;
  wire        MOUSE_DATA  = dev_data & t_data;

  int total = 0;
  int bad   = 0;

  byte unsigned q [$];
  bit m_pe, m_fe, m_ov, m_to, m_ack;

  ps2_host_port #(.FIFO_AW(3), .FILTER_LEN(4), .INHIBIT_CYCLES(50), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .io_cs(io_cs), .io_we(io_we), .addr(addr), .wdata(wdata),
    .data(data), .rda(rda), .irq(irq), .t_clk(t_clk), .t_data(t_data),
    .MOUSE_CLOCK(MOUSE_CLOCK), .MOUSE_DATA(MOUSE_DATA));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    io_cs = 1'b1; io_we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    io_cs = 1'b0; io_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    io_cs = 1'b1; io_we = 1'b0; addr = a;
    #1 d = data;
    @(posedge clk); #1;
    io_cs = 1'b0;
  endtask

  function automatic bit odd_par(input byte unsigned b);
    return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [7:0] exp_status();
    return {1'b1, 1'b0, (q.size() != 0), m_ack, m_to, m_ov, m_fe, m_pe};
  endfunction

  // Device drives the first n bits of an 11-bit frame, 40 clk cycles per bit.
  task automatic dev_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      dev_data = bits[i];
      wait_clk(10);
      dev_clk = 1'b0;
      wait_clk(20);
      dev_clk = 1'b1;
      wait_clk(10);
    end
    dev_data = 1'b1;
  endtask

  // Full device frame plus the model's view of its outcome.
  task automatic send_frame(input byte unsigned b, input bit par, input bit stp);
    dev_bits({stp, par, b, 1'b0}, 11);
    wait_clk(20);
    if (par != odd_par(b))  m_pe = 1'b1;
    else if (!stp)          m_fe = 1'b1;
    else if (q.size() == 8) m_ov = 1'b1;
    else                    q.push_back(b);
  endtask

  task automatic read_check(input string tag);
    logic [7:0] d;
    byte unsigned e;
    e = (q.size() != 0) ? q.pop_front() : 8'h00;
    bus_rd(2'd0, d);
    chk(tag, d, e);
  endtask

  task automatic status_check(input string tag);
    logic [7:0] d;
    bus_rd(2'd1, d);
    chk(tag, d, exp_status());
    chk({tag, "_irq"}, irq, (q.size() != 0) | m_pe | m_fe | m_ov | m_to | m_ack);
  endtask

  task automatic ctl_write(input logic [1:0] ops);
    bus_wr(2'd3, {5'b0, 1'b1, ops});
    if (ops[0]) {m_pe, m_fe, m_ov, m_to, m_ack} = '0;
    if (ops[1]) q.delete();
  endtask

  // Device side of a host command: clock 11 falls, capture bits, optionally ack.
  task automatic dev_tx(input bit do_ack, output logic [7:0] b, output logic par, output logic rel);
    logic [10:0] s;
    bit ready = 1'b0;
    for (int i = 0; i < 400 && !ready; i++) begin
      @(negedge clk);
      if (t_clk === 1'b1 && t_data === 1'b0) ready = 1'b1;
    end
    chk("tx_request_seen", ready, 1'b1);
    wait_clk(20);
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && do_ack) dev_data = 1'b0;
      wait_clk(5);
      dev_clk = 1'b0;
      wait_clk(19);
      s[i] = MOUSE_DATA;
      wait_clk(1);
      dev_clk = 1'b1;
      wait_clk(15);
      dev_data = 1'b1;
    end
    b   = s[7:0];
    par = s[8];
    rel = s[9];
    if (!do_ack) m_ack = 1'b1;
    wait_clk(10);
  endtask

  initial begin
    logic [7:0] d, tb, tp;
    logic tpar, trel;
    int inh;
    bit seen;

    wait_clk(3);
    chk("reset_t_clk", t_clk, 1'b1);
    chk("reset_t_data", t_data, 1'b1);
    chk("reset_rda", rda, 1'b0);
    chk("reset_irq", irq, 1'b0);
    rst = 1'b1;
    wait_clk(3);
    status_check("reset_status");
    read_check("empty_read");

    // Good 0xFA
    send_frame(8'hFA, 1'b1, 1'b1);
    chk("fa_rda", rda, 1'b1);
    read_check("fa_read");
    bus_rd(2'd1, d);
    chk("fa_rda_bit_after_pop", d[5], 1'b0);

    // Bad parity, then clear
    send_frame(8'hFA, 1'b0, 1'b1);
    chk("perr_rda", rda, 1'b0);
    status_check("perr_status");
    ctl_write(2'b01);
    status_check("perr_cleared");

    // Framing error
    send_frame(8'h3C, odd_par(8'h3C), 1'b0);
    status_check("ferr_status");
    ctl_write(2'b01);

    // Overflow on the ninth byte, then drain
    for (int i = 1; i <= 9; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1);
    status_check("ovf_status");
    for (int i = 0; i < 8; i++) read_check("ovf_drain");
    chk("ovf_rda_empty", rda, 1'b0);
    ctl_write(2'b01);

    // Randomised receive traffic with interleaved reads, clears and flushes
    for (int it = 0; it < 24; it++) begin
      byte unsigned b;
      int kind, nr;
      b    = 8'($urandom);
      kind = $urandom_range(0, 5);
      send_frame(b, (kind == 4) ? ~odd_par(b) : odd_par(b), kind != 5);
      nr = $urandom_range(0, 2);
      for (int r = 0; r < nr; r++) read_check("rand_read");
      status_check("rand_status");
      if (it % 6 == 5) begin
        ctl_write(2'($urandom_range(1, 3)));
        status_check("rand_ctl_status");
      end
    end
    ctl_write(2'b11);

    // Host command 0xF4 with ack
    bus_wr(2'd2, 8'hF4);
    inh  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (t_data === 1'b0) seen = 1'b1;
      else if (t_clk === 1'b0) inh++;
    end
    chk("tx_req_data_low", seen, 1'b1);
    chk("tx_inhibit_len", inh, 50);
    chk("tx_req_clk_still_low", t_clk, 1'b0);
    @(negedge clk);
    chk("tx_clk_released", t_clk, 1'b1);
    chk("tx_start_bit", t_data, 1'b0);
    dev_tx(1'b1, tb, tpar, trel);
    chk("tx_f4_bits", tb, 8'hF4);
    chk("tx_f4_parity", tpar, 1'b0);
    chk("tx_f4_release", trel, 1'b1);
    status_check("tx_f4_status");

    // Random host commands, some without ack
    for (int it = 0; it < 4; it++) begin
      bit ack;
      tp  = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      bus_wr(2'd2, tp);
      bus_wr(2'd2, ~tp);
      dev_tx(ack, tb, tpar, trel);
      chk("tx_rand_bits", tb, tp);
      chk("tx_rand_parity", tpar, odd_par(tp));
      chk("tx_rand_release", trel, 1'b1);
      status_check("tx_rand_status");
    end
    ctl_write(2'b01);

    // Device stalls after four data bits
    dev_bits({2'b11, 8'h55, 1'b0}, 5);
    wait_clk(100);
    status_check("to_not_yet");
    wait_clk(120);
    m_to = 1'b1;
    status_check("to_set");
    send_frame(8'hAA, odd_par(8'hAA), 1'b1);
    read_check("to_recover_read");
    ctl_write(2'b01);
    status_check("to_cleared");

    // Reset during transmission at bit 3
    bus_wr(2'd2, 8'h5A);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (t_clk === 1'b1 && t_data === 1'b0) seen = 1'b1;
    end
    chk("rst_tx_started", seen, 1'b1);
    wait_clk(20);
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0;
      wait_clk(20);
      dev_clk = 1'b1;
      wait_clk(20);
    end
    dev_clk = 1'b0;
    wait_clk(10);
    #2 rst = 1'b0;
    #1;
    chk("rst_t_clk", t_clk, 1'b1);
    chk("rst_t_data", t_data, 1'b1);
    dev_clk = 1'b1;
    q.delete();
    {m_pe, m_fe, m_ov, m_to, m_ack} = '0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(3);
    bus_rd(2'd1, d);
    chk("rst_status", d, 8'h80);
    chk("rst_irq", irq, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
